// File: rtl/fpadd_arbiter.sv
// Two-requester front end for a shared fixed-latency pipelined fpadd: arbitrates, issues, and routes sums back by tag.
// Define FPADD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); default is round-robin.
module fpadd_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADD_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic                  res0_valid,
   output logic [DATA_WIDTH-1:0] res0_data,
   output logic                  res1_valid,
   output logic [DATA_WIDTH-1:0] res1_data,
   output logic                  add_valid_in,
   output logic [DATA_WIDTH-1:0] add_in1,
   output logic [DATA_WIDTH-1:0] add_in2,
   input  logic [DATA_WIDTH-1:0] add_product,
   input  logic                  add_valid_out,
   output logic                  err
);

   logic                   grant0;
   logic                   grant1;
   logic                   tag_in;
   logic [ADD_LATENCY-1:0] tag_vld;
   logic [ADD_LATENCY-1:0] tag_id;

`ifdef FPADD_ARB_FIXED_PRIO_EN
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid)      grant0 = 1'b1;
      else if (req1_valid) grant1 = 1'b1;
      if (!resetn) begin
         grant0 = 1'b0;
         grant1 = 1'b0;
      end
   end
`else
   logic last;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0 = last;
         grant1 = !last;
      end else if (req0_valid) begin
         grant0 = 1'b1;
      end else if (req1_valid) begin
         grant1 = 1'b1;
      end
      if (!resetn) begin
         grant0 = 1'b0;
         grant1 = 1'b0;
      end
   end

   // Reset to 1 so requester 0 wins the first contention; only moves on a real grant.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     last <= 1'b1;
      else if (grant0) last <= 1'b0;
      else if (grant1) last <= 1'b1;
   end
`endif

   // Ready is the grant itself and is held low while reset is asserted.
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         add_valid_in <= 1'b0;
         add_in1      <= '0;
         add_in2      <= '0;
         tag_in       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         add_valid_in <= grant0 || grant1;
         if (grant0 || grant1) begin
            add_in1 <= grant1 ? req1_a : req0_a;
            add_in2 <= grant1 ? req1_b : req0_b;
            tag_in  <= grant1;
         end
      end
   end

   // Tag stage i lines up with adder pipeline stage i; the last stage meets add_valid_out.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld[0] <= add_valid_in;
         tag_id[0]  <= tag_in;
         for (int i = 1; i < ADD_LATENCY; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_id[i]  <= tag_id[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res0_valid <= 1'b0;
         res1_valid <= 1'b0;
         res0_data  <= '0;
         res1_data  <= '0;
         err        <= 1'b0;
      end else begin
         res0_valid <= add_valid_out && !tag_id[ADD_LATENCY-1];
         res1_valid <= add_valid_out &&  tag_id[ADD_LATENCY-1];
         if (add_valid_out && !tag_id[ADD_LATENCY-1]) res0_data <= add_product;
         if (add_valid_out &&  tag_id[ADD_LATENCY-1]) res1_data <= add_product;
         // Sticky: the adder produced (or dropped) a result the tag pipeline did not predict.
         if (add_valid_out != tag_vld[ADD_LATENCY-1]) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: behavioural fpadd model plus a scoreboard of expected {requester, sum, cycle}.
// Honours FPADD_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_fpadd_arbiter;
   localparam int W = 32;
   localparam int L = 3;

   logic         clk = 1'b0;
   logic         resetn;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         res0_valid, res1_valid;
   logic [W-1:0] res0_data, res1_data;
   logic         add_valid_in;
   logic [W-1:0] add_in1, add_in2, add_product;
   logic         add_valid_out;
   logic         err;

   logic         add_force  = 1'b0;
   logic         ignore_res = 1'b0;
   logic         err_exp    = 1'b0;
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;

   typedef struct {
      logic         id;
      logic [W-1:0] data;
      int           due;
   } exp_t;
   exp_t sb[$];
   int   grant_log[$];

   fpadd_arbiter #(.DATA_WIDTH(W), .ADD_LATENCY(L)) dut (
      .clk(clk), .resetn(resetn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .res0_valid(res0_valid), .res0_data(res0_data),
      .res1_valid(res1_valid), .res1_data(res1_data),
      .add_valid_in(add_valid_in), .add_in1(add_in1), .add_in2(add_in2),
      .add_product(add_product), .add_valid_out(add_valid_out), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Normal single-precision values only; exact for the sums used here.
   function automatic real sp_to_real(input logic [31:0] a);
      if (a[30:0] == 31'd0) return 0.0;
      return $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] sp_add(input logic [31:0] a, input logic [31:0] b);
      real          r;
      logic [63:0]  d;
      logic [10:0]  e;
      r = sp_to_real(a) + sp_to_real(b);
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Behavioural fpadd: fixed latency L, cleared by the shared reset.
   logic [L-1:0] m_vld;
   logic [W-1:0] m_sum [L];
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_vld <= '0;
         for (int i = 0; i < L; i++) m_sum[i] <= '0;
      end else begin
         m_vld[0] <= add_valid_in;
         m_sum[0] <= sp_add(add_in1, add_in2);
         for (int i = 1; i < L; i++) begin
            m_vld[i] <= m_vld[i-1];
            m_sum[i] <= m_sum[i-1];
         end
      end
   end
   assign add_valid_out = m_vld[L-1] | add_force;
   assign add_product   = m_sum[L-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!resetn) begin
         check("rst_ctrl", {58'd0, req0_ready, req1_ready, add_valid_in, res0_valid, res1_valid, err}, 64'd0);
         check("rst_add_in", {add_in1, add_in2}, 64'd0);
         check("rst_res_data", {res0_data, res1_data}, 64'd0);
      end else begin
         check("one_ready", 64'(req0_ready & req1_ready), 64'd0);
         if (req0_valid && req0_ready) begin
            sb.push_back('{1'b0, sp_add(req0_a, req0_b), cyc + L + 2});
            grant_log.push_back(0);
         end
         if (req1_valid && req1_ready) begin
            sb.push_back('{1'b1, sp_add(req1_a, req1_b), cyc + L + 2});
            grant_log.push_back(1);
         end
         if (!ignore_res) begin
            check("res_exclusive", 64'(res0_valid & res1_valid), 64'd0);
            if (res0_valid || res1_valid) begin
               checks++;
               assert (sb.size() > 0) else begin
                  errors++;
                  $error("FAIL res_unexpected: observed res0/res1 valid %b%b expected none", res0_valid, res1_valid);
               end
               if (sb.size() > 0) begin
                  exp_t e;
                  e = sb.pop_front();
                  check("res_id", 64'(res1_valid), 64'(e.id));
                  check("res_data", 64'(res1_valid ? res1_data : res0_data), 64'(e.data));
                  check("res_cycle", 64'(cyc), 64'(e.due));
               end
            end
         end
         check("err", 64'(err), 64'(err_exp));
      end
   end

   // One cycle of stimulus, entered just after a rising edge; returns grants and add_valid_in seen that cycle.
   task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                        output logic g0, output logic g1, output logic av);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      @(negedge clk);
      g0 = req0_valid && req0_ready;
      g1 = req1_valid && req1_ready;
      av = add_valid_in;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic g0, g1, av;
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, g0, g1, av);
   endtask

   task automatic drain();
      int n = 0;
      idle(1);
      while (sb.size() > 0 && n < 30) begin
         idle(1);
         n++;
      end
      check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   task automatic reset_dut();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resetn     = 1'b0;
      err_exp    = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic g0, g1, av;
      int   sent0, sent1, k;
      resetn = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(2);

      // Single op from requester 0: 1.0 + 2.0.
      drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, '0, '0, g0, g1, av);
      check("single_ready", {62'd0, g0, g1}, 64'd2);
      drain();

      // Contention: four ops per requester offered continuously.
      reset_dut();
      grant_log.delete();
      sent0 = 0; sent1 = 0; k = 0;
      while ((sent0 < 4 || sent1 < 4) && k < 20) begin
         drive(sent0 < 4, 32'h3F80_0000, 32'h3F80_0000,
               sent1 < 4, 32'h3F00_0000, 32'h3F80_0000, g0, g1, av);
         sent0 += int'(g0);
         sent1 += int'(g1);
         k++;
      end
      check("contention_cycles", 64'(k), 64'd8);
      check("contention_grants", 64'(grant_log.size()), 64'd8);
      for (int i = 0; i < grant_log.size(); i++) begin
`ifdef FPADD_ARB_FIXED_PRIO_EN
         check("fixed_grant_order", 64'(grant_log[i]), (i < 4) ? 64'd0 : 64'd1);
`else
         check("rr_grant_order", 64'(grant_log[i]), 64'(i % 2));
`endif
      end
      drain();

      // Gaps: requester 1 on relative cycles 0, 1, 4.
      reset_dut();
      drive(1'b0, '0, '0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, g0, g1, av);
      check("gap_grant0", 64'(g1), 64'd1);
      drive(1'b0, '0, '0, 1'b1, 32'h4000_0000, 32'h4040_0000, g0, g1, av);
      check("gap_grant1", 64'(g1), 64'd1);
      drive(1'b0, '0, '0, 1'b0, '0, '0, g0, g1, av);
      check("gap_issue_hi", 64'(av), 64'd1);
      drive(1'b0, '0, '0, 1'b0, '0, '0, g0, g1, av);
      check("gap_issue_lo_a", 64'(av), 64'd0);
      drive(1'b0, '0, '0, 1'b1, 32'h3F00_0000, 32'h3F00_0000, g0, g1, av);
      check("gap_issue_lo_b", 64'(av), 64'd0);
      check("gap_grant2", 64'(g1), 64'd1);
      drain();

      // Reset two cycles after three back-to-back issues; in-flight sums must vanish.
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, '0, '0, g0, g1, av);
         check("mid_issue", 64'(g0), 64'd1);
      end
      idle(1);
      resetn = 1'b0;
      req0_valid = 1'b1;
      sb.delete();
      @(negedge clk);
      check("mid_ready_in_reset", 64'(req0_ready), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(8);
      drive(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0, '0, '0, g0, g1, av);
      check("post_reset_grant", 64'(g0), 64'd1);
      drain();

      // Spurious adder valid with nothing in flight.
      add_force  = 1'b1;
      ignore_res = 1'b1;
      idle(1);
      add_force = 1'b0;
      err_exp   = 1'b1;
      check("err_set", 64'(err), 64'd1);
      idle(4);
      ignore_res = 1'b0;
      check("err_sticky", 64'(err), 64'd1);
      reset_dut();
      check("err_cleared", 64'(err), 64'd0);
      drive(1'b0, '0, '0, 1'b1, 32'h4080_0000, 32'h4000_0000, g0, g1, av);
      check("final_grant", 64'(g1), 64'd1);
      drain();

      check("final_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
